// File: rtl/risc16_pkg.sv
// Shared RiSC-16 widths and the fetch queue entry layout.
package risc16_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned ADDR_W = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [WORD_W-1:0] instr;
    logic              filled;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order fetch queue: entries are allocated with their PC on request acceptance, filled with
// the instruction when the response arrives, and freed when decode pops the head.
module fetch_queue
  import risc16_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              alloc,
  input  logic [ADDR_W-1:0] alloc_pc,
  input  logic              fill,
  input  logic [WORD_W-1:0] fill_instr,
  input  logic              pop,
  output logic              head_filled,
  output logic [ADDR_W-1:0] head_pc,
  output logic [WORD_W-1:0] head_instr,
  output logic [PTR_W-1:0]  alloc_cnt,
  output logic [PTR_W-1:0]  unfilled_cnt
);

  localparam int unsigned IDX_W = PTR_W - 1;

  fetch_entry_t     entries_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, fill_ptr_q, rd_ptr_q;
  logic [IDX_W-1:0] wr_idx, fill_idx, rd_idx;

  assign wr_idx   = wr_ptr_q[IDX_W-1:0];
  assign fill_idx = fill_ptr_q[IDX_W-1:0];
  assign rd_idx   = rd_ptr_q[IDX_W-1:0];

  // Responses come back in order, so the filled entries always sit between rd and fill.
  assign alloc_cnt    = wr_ptr_q - rd_ptr_q;
  assign unfilled_cnt = wr_ptr_q - fill_ptr_q;

  assign head_filled = (alloc_cnt != '0) & entries_q[rd_idx].filled;
  assign head_pc     = entries_q[rd_idx].pc;
  assign head_instr  = entries_q[rd_idx].instr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      fill_ptr_q <= '0;
      rd_ptr_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) entries_q[i] <= '0;
    end else if (clear) begin
      wr_ptr_q   <= '0;
      fill_ptr_q <= '0;
      rd_ptr_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) entries_q[i].filled <= 1'b0;
    end else begin
      if (alloc) begin
        entries_q[wr_idx].pc     <= alloc_pc;
        entries_q[wr_idx].filled <= 1'b0;
        wr_ptr_q                 <= wr_ptr_q + PTR_W'(1);
      end
      if (fill) begin
        entries_q[fill_idx].instr  <= fill_instr;
        entries_q[fill_idx].filled <= 1'b1;
        fill_ptr_q                 <= fill_ptr_q + PTR_W'(1);
      end
      // Placed after fill: a bypassed response fills and frees the head in the same cycle.
      if (pop) begin
        entries_q[rd_idx].filled <= 1'b0;
        rd_ptr_q                 <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// RiSC-16 instruction fetch: credit-limited PC-tagged requests, in-order response queue and
// flush handling. Define IF_BYPASS_EN to forward a response into an empty queue straight to decode.
module instr_fetch
  import risc16_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_adv,
  input  logic              flush,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic              if_valid,
  output logic [WORD_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  input  logic              if_ready
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0]  alloc_cnt, unfilled_cnt, pending;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic [CNT_W:0]    used;
  logic              accept, pop, resp_owed, resp_fill, head_filled;
  logic [WORD_W-1:0] head_instr;
  logic [ADDR_W-1:0] head_pc;

  // Responses still owed from before a flush hold their credit until they drain.
  assign used      = {1'b0, alloc_cnt} + {1'b0, drop_cnt_q};
  assign imem_req  = ~rst & ~flush & (used < (CNT_W + 1)'(DEPTH));
  assign imem_addr = pc_in;
  assign accept    = imem_req & imem_gnt;
  assign pc_adv    = accept;

  assign resp_owed = (drop_cnt_q != '0);
  assign resp_fill = imem_rvalid & ~resp_owed & (unfilled_cnt != '0) & ~flush;
  assign pop       = if_valid & if_ready & ~flush;
  assign pending   = drop_cnt_q + unfilled_cnt;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (flush) begin
      drop_cnt_d = (imem_rvalid && pending != '0) ? pending - CNT_W'(1) : pending;
    end else if (imem_rvalid && resp_owed) begin
      drop_cnt_d = drop_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk          (clk),
    .rst          (rst),
    .clear        (flush),
    .alloc        (accept),
    .alloc_pc     (pc_in),
    .fill         (resp_fill),
    .fill_instr   (imem_rdata),
    .pop          (pop),
    .head_filled  (head_filled),
    .head_pc      (head_pc),
    .head_instr   (head_instr),
    .alloc_cnt    (alloc_cnt),
    .unfilled_cnt (unfilled_cnt)
  );

`ifdef IF_BYPASS_EN
  // With no filled entry, the oldest unfilled entry is the head, so this fill lands on it.
  logic bypass;
  assign bypass   = resp_fill & ~head_filled;
  assign if_valid = head_filled | bypass;
  assign if_instr = bypass ? imem_rdata : head_instr;
`else
  assign if_valid = head_filled;
  assign if_instr = head_instr;
`endif
  assign if_pc = head_pc;

  a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (rst)
    imem_rvalid |-> (resp_owed || unfilled_cnt != '0));

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized self-checking bench for instr_fetch against a queue-based fetch/memory model.
module tb_instr_fetch;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, flush, pc_adv, imem_req, imem_gnt, imem_rvalid, if_valid, if_ready;
  logic [15:0] pc_in, imem_addr, imem_rdata, if_instr, if_pc;

  always #5 clk = ~clk;

  instr_fetch #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_in       (pc_in),
    .pc_adv      (pc_adv),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_ready    (if_ready)
  );

  typedef struct {
    logic [15:0] pc;
    bit          arrived;
  } exp_ent_t;

  typedef struct {
    logic [15:0] pc;
    bit          stale;
    int          due;
  } mem_ent_t;

  exp_ent_t exp_q[$];  // what decode should still see, oldest first
  mem_ent_t mem_q[$];  // requests the memory still has to answer

  int checks = 0, errors = 0, cyc = 0;
  int lat_min = 1, lat_max = 1;
  logic        e_req, e_adv, e_valid, o_req, o_adv, o_valid;
  logic [15:0] e_pc, e_instr, o_pc, o_instr, o_addr;

  function automatic logic [15:0] word_of(input logic [15:0] pc);
    return {pc[7:0], pc[15:8]} ^ 16'hC3A5;
  endfunction

  function automatic int stale_cnt();
    int n = 0;
    foreach (mem_q[i]) if (mem_q[i].stale) n++;
    return n;
  endfunction

  task automatic drive_mem();
    imem_rvalid = 1'b0;
    imem_rdata  = 16'h0;
    if (mem_q.size() > 0) begin
      if (mem_q[0].due <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = word_of(mem_q[0].pc);
      end
    end
  endtask

  // One clock: predict and sample at negedge, advance the model at posedge, drive memory after.
  task automatic tick();
    int       free;
    mem_ent_t m;
    @(negedge clk);
    free    = int'(DEPTH) - exp_q.size() - stale_cnt();
    e_req   = !rst && !flush && free > 0;
    e_adv   = e_req && imem_gnt;
    e_valid = 1'b0;
    e_pc    = 16'h0;
    e_instr = 16'h0;
    if (!rst && exp_q.size() > 0) begin
      e_valid = exp_q[0].arrived;
`ifdef IF_BYPASS_EN
      if (!exp_q[0].arrived && imem_rvalid && !flush && !mem_q[0].stale) e_valid = 1'b1;
`endif
      e_pc    = exp_q[0].pc;
      e_instr = word_of(exp_q[0].pc);
    end
    o_req   = imem_req;
    o_adv   = pc_adv;
    o_valid = if_valid;
    o_pc    = if_pc;
    o_instr = if_instr;
    o_addr  = imem_addr;
    @(posedge clk);
    cyc++;
    if (rst) begin
      exp_q.delete();
      mem_q.delete();
    end else begin
      if (imem_rvalid) begin
        m = mem_q.pop_front();
        if (!m.stale && !flush) begin
          for (int i = 0; i < exp_q.size(); i++) begin
            if (!exp_q[i].arrived) begin
              exp_q[i].arrived = 1'b1;
              break;
            end
          end
        end
      end
      if (e_valid && if_ready && !flush) void'(exp_q.pop_front());
      if (e_adv) begin
        exp_q.push_back('{pc: pc_in, arrived: 1'b0});
        mem_q.push_back('{pc: pc_in, stale: 1'b0,
                          due: cyc + int'($urandom_range(lat_max, lat_min)) - 1});
      end
      if (flush) begin
        foreach (mem_q[i]) mem_q[i].stale = 1'b1;
        exp_q.delete();
      end
    end
    #1;
    if (e_adv) pc_in = pc_in + 16'd1;
    drive_mem();
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; imem_gnt = 1'b0; if_ready = 1'b0; pc_in = 16'h0;
    imem_rvalid = 1'b0; imem_rdata = 16'h0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; imem_gnt = 1'b1; if_ready = 1'b1; pc_in = 16'h1234;
    imem_rvalid = 1'b0; imem_rdata = 16'h0;
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({imem_req, pc_adv, if_valid} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctl got %b want 000", {imem_req, pc_adv, if_valid});
    end
    checks++;
    if ({if_instr, if_pc} !== 32'h0) begin
      errors++;
      $display("FAIL reset_data got %h want 0", {if_instr, if_pc});
    end
    do_reset();
  endtask

  task automatic test_stream();
    int first = -1, pops = 0;
    do_reset();
    lat_min = 1; lat_max = 1; imem_gnt = 1'b1; if_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      tick();
      checks++;
      if ({o_req, o_adv, o_valid} !== {e_req, e_adv, e_valid}) begin
        errors++;
        $display("FAIL stream_ctl @%0d got %b want %b", cyc, {o_req, o_adv, o_valid},
                 {e_req, e_adv, e_valid});
      end
      if (e_valid) begin
        checks++;
        if ({o_pc, o_instr} !== {e_pc, e_instr}) begin
          errors++;
          $display("FAIL stream_data @%0d got %h want %h", cyc, {o_pc, o_instr}, {e_pc, e_instr});
        end
      end
      if (o_valid) begin
        pops++;
        if (first < 0) first = i;
      end
    end
`ifdef IF_BYPASS_EN
    checks++;
    if (first !== 1) begin errors++; $display("FAIL stream_latency got %0d want 1", first); end
    checks++;
    if (pops !== 23) begin errors++; $display("FAIL stream_rate got %0d want 23", pops); end
`else
    checks++;
    if (first !== 2) begin errors++; $display("FAIL stream_latency got %0d want 2", first); end
    checks++;
    if (pops !== 22) begin errors++; $display("FAIL stream_rate got %0d want 22", pops); end
`endif
  endtask

  task automatic test_backpressure();
    int          advs = 0, pops = 0;
    bit          resumed = 0;
    logic [15:0] base;
    do_reset();
    base = 16'h0;
    lat_min = 1; lat_max = 1; imem_gnt = 1'b1; if_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if ({o_req, o_adv, o_valid} !== {e_req, e_adv, e_valid}) begin
        errors++;
        $display("FAIL bp_fill_ctl @%0d got %b want %b", cyc, {o_req, o_adv, o_valid},
                 {e_req, e_adv, e_valid});
      end
      advs += int'(o_adv);
    end
    checks++;
    if (advs !== 4) begin errors++; $display("FAIL bp_accepts got %0d want 4", advs); end
    checks++;
    if (o_req !== 1'b0) begin errors++; $display("FAIL bp_full_req got %b want 0", o_req); end
    if_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if ({o_req, o_adv, o_valid} !== {e_req, e_adv, e_valid}) begin
        errors++;
        $display("FAIL bp_drain_ctl @%0d got %b want %b", cyc, {o_req, o_adv, o_valid},
                 {e_req, e_adv, e_valid});
      end
      if (o_req) resumed = 1;
      if (o_valid && pops < 4) begin
        checks++;
        if (o_pc !== base + 16'(pops)) begin
          errors++;
          $display("FAIL bp_order got %h want %h", o_pc, base + 16'(pops));
        end
        pops++;
      end
    end
    checks++;
    if (pops !== 4 || !resumed) begin
      errors++;
      $display("FAIL bp_drain got pops=%0d resumed=%0d want pops=4 resumed=1", pops, resumed);
    end
  endtask

  task automatic test_flush();
    bit seen = 0;
    do_reset();
    lat_min = 3; lat_max = 3; imem_gnt = 1'b1; if_ready = 1'b1; pc_in = 16'h0010;
    repeat (2) tick();
    imem_gnt = 1'b0; flush = 1'b1; pc_in = 16'h0040;
    tick();
    flush = 1'b0; imem_gnt = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      checks++;
      if ({o_req, o_adv, o_valid} !== {e_req, e_adv, e_valid}) begin
        errors++;
        $display("FAIL flush_ctl @%0d got %b want %b", cyc, {o_req, o_adv, o_valid},
                 {e_req, e_adv, e_valid});
      end
      if (o_valid) begin
        seen = 1;
        checks++;
        if ({o_pc, o_instr} !== {16'h0040, word_of(16'h0040)}) begin
          errors++;
          $display("FAIL flush_first got %h want %h", {o_pc, o_instr},
                   {16'h0040, word_of(16'h0040)});
        end
      end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL flush_timeout got none want if_pc 0040"); end
  endtask

  task automatic test_flush_collide();
    bit hit = 0;
    do_reset();
    lat_min = 2; lat_max = 2; imem_gnt = 1'b1; if_ready = 1'b0; pc_in = 16'h0100;
    for (int i = 0; i < 10 && !hit; i++) begin
      tick();
      hit = imem_rvalid && if_valid;
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL collide_setup got 0 want 1"); end
    flush = 1'b1; if_ready = 1'b1; pc_in = 16'h0200;
    tick();
    checks++;
    if ({o_req, o_adv} !== 2'b00) begin
      errors++;
      $display("FAIL collide_flush got %b want 00", {o_req, o_adv});
    end
    flush = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick();
      checks++;
      if ({o_req, o_adv, o_valid} !== {e_req, e_adv, e_valid}) begin
        errors++;
        $display("FAIL collide_ctl @%0d got %b want %b", cyc, {o_req, o_adv, o_valid},
                 {e_req, e_adv, e_valid});
      end
      if (e_valid) begin
        checks++;
        if ({o_pc, o_instr} !== {e_pc, e_instr}) begin
          errors++;
          $display("FAIL collide_data @%0d got %h want %h", cyc, {o_pc, o_instr}, {e_pc, e_instr});
        end
      end
    end
  endtask

  task automatic test_no_grant();
    int advs = 0, pops = 0;
    do_reset();
    lat_min = 1; lat_max = 1; imem_gnt = 1'b1; if_ready = 1'b0; pc_in = 16'h0300;
    repeat (2) tick();
    imem_gnt = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if ({o_req, o_adv, o_valid} !== {e_req, e_adv, e_valid}) begin
        errors++;
        $display("FAIL nogrant_ctl @%0d got %b want %b", cyc, {o_req, o_adv, o_valid},
                 {e_req, e_adv, e_valid});
      end
      advs += int'(o_adv);
    end
    checks++;
    if (advs !== 0) begin errors++; $display("FAIL nogrant_adv got %0d want 0", advs); end
    if_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (e_valid) begin
        checks++;
        if ({o_pc, o_instr} !== {e_pc, e_instr}) begin
          errors++;
          $display("FAIL nogrant_data @%0d got %h want %h", cyc, {o_pc, o_instr}, {e_pc, e_instr});
        end
      end
      pops += int'(o_valid);
    end
    checks++;
    if (pops !== 2) begin errors++; $display("FAIL nogrant_pops got %0d want 2", pops); end
  endtask

  task automatic test_random();
    do_reset();
    lat_min = 1; lat_max = 3;
    for (int i = 0; i < 600; i++) begin
      imem_gnt = ($urandom_range(3) != 0);
      if_ready = ($urandom_range(3) != 0);
      flush    = ($urandom_range(15) == 0);
      if (flush || $urandom_range(7) == 0) pc_in = 16'($urandom);
      tick();
      checks++;
      if ({o_req, o_adv, o_valid} !== {e_req, e_adv, e_valid}) begin
        errors++;
        $display("FAIL rand_ctl @%0d got %b want %b", cyc, {o_req, o_adv, o_valid},
                 {e_req, e_adv, e_valid});
      end
      if (e_valid) begin
        checks++;
        if ({o_pc, o_instr} !== {e_pc, e_instr}) begin
          errors++;
          $display("FAIL rand_data @%0d got %h want %h", cyc, {o_pc, o_instr}, {e_pc, e_instr});
        end
      end
      checks++;
      if (imem_addr !== pc_in) begin
        errors++;
        $display("FAIL rand_addr @%0d got %h want %h", cyc, imem_addr, pc_in);
      end
    end
    flush = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    lat_min = 1; lat_max = 2; imem_gnt = 1'b1; if_ready = 1'b1; pc_in = 16'h0500;
    repeat (6) tick();
    #2 rst = 1'b1;
    imem_rvalid = 1'b0;
    #1;
    checks++;
    if ({imem_req, pc_adv, if_valid, if_instr, if_pc} !== 35'h0) begin
      errors++;
      $display("FAIL async_rst got %b%b%b %h %h want all zero", imem_req, pc_adv, if_valid,
               if_instr, if_pc);
    end
    repeat (2) tick();
    rst = 1'b0; pc_in = 16'h0;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if ({o_req, o_adv, o_valid} !== {e_req, e_adv, e_valid}) begin
        errors++;
        $display("FAIL restart_ctl @%0d got %b want %b", cyc, {o_req, o_adv, o_valid},
                 {e_req, e_adv, e_valid});
      end
      if (e_valid) begin
        checks++;
        if ({o_pc, o_instr} !== {e_pc, e_instr}) begin
          errors++;
          $display("FAIL restart_data @%0d got %h want %h", cyc, {o_pc, o_instr}, {e_pc, e_instr});
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_flush_collide();
    test_no_grant();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the RiSC-16 processor, directly downstream of the program counter. Each cycle it offers the current PC to instruction memory and tags every accepted request with its PC. It buffers in-order responses in a small queue and presents {instruction, PC} to decode with a valid/ready handshake. On a redirect it flushes buffered and in-flight fetches, so decode only sees instructions from the new path.

## Interface
- DEPTH, 4, queue entries (power of two, ≥2); also bounds outstanding requests
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- pc_in  in  16  fetch address from the PC stage
- pc_adv  out  1  pulse: pc_in accepted by memory this cycle, so PC may advance
- flush  in  1  redirect (branch/jump taken); discard all queued and in-flight fetches
- imem_req  out  1  fetch request valid
- imem_addr  out  16  fetch address (= pc_in)
- imem_gnt  in  1  memory accepts request this cycle
- imem_rvalid  in  1  response valid (in order, one per accepted request, ≥1 cycle after gnt)
- imem_rdata  in  16  instruction word
- if_valid  out  1  instruction available to decode
- if_instr  out  16  instruction word at queue head
- if_pc  out  16  PC of that instruction
- if_ready  in  1  decode accepts head this cycle

## Operation
- Entry state: allocated at request acceptance (stores pc_in), filled at imem_rvalid (stores rdata), freed at pop.
- alloc_cnt = allocated entries (filled or not); drop_cnt = responses still owed from before a flush.
- credits = DEPTH − alloc_cnt − drop_cnt; imem_req = (credits > 0) & ~flush.
- Accept = imem_req & imem_gnt: allocate tail, pc_adv = 1.
- Response with drop_cnt > 0: discard, drop_cnt −1. Otherwise fill the oldest unfilled entry.
- if_valid = head entry filled; pop on if_valid & if_ready.
- Flush: clear all entries and pointers. drop_cnt ← drop_cnt + (allocated-unfilled count), minus 1 if a response arrives that cycle. No accept or pop takes effect in a flush cycle.
- Pointers are log2(DEPTH)+1 bits; wrap naturally. Full = credits == 0.
- Response with no owed/unfilled slot is a protocol error: ignored (assertion in sim).

## Timing
- Reset values: imem_req 0, pc_adv 0, if_valid 0, if_instr 0, if_pc 0, all counters 0. imem_req may assert in the first cycle after rst deasserts.
- imem_req, imem_addr and pc_adv are combinational from state, pc_in, flush and imem_gnt.
- rvalid → if_valid: 1 cycle (registered queue).
- Steady state with single-cycle memory and decode always ready: one instruction per cycle.
- Simultaneous accept + pop: both occur and occupancy is unchanged.
- Simultaneous rvalid + flush: the response counts against pre-flush owed responses and is dropped.
- rst mid-operation clears drop_cnt. The memory is reset on the same rst, so nothing is owed.

## Configuration
- IF_BYPASS_EN defined: when the queue has no filled entry and the response fills the head entry, if_valid/if_instr/if_pc are driven combinationally from imem_rdata in the same cycle. Pop that cycle if if_ready (0-cycle latency).
- Undefined: all outputs come from registered queue storage; latency is 1 cycle.

## Structure
- risc16_pkg: WORD_W = 16, ADDR_W = 16, fetch entry struct {pc, instr, filled}.
- Sub-module fetch_queue: storage, alloc/fill/read pointers, alloc_cnt. instr_fetch holds the credit logic, drop_cnt, the handshakes and the bypass mux.

## Test plan
- Reset, imem_gnt = 1, 1-cycle rvalid, if_ready = 1, pc_in 0,1,2… → if_pc 0,1,2… with matching rdata, one per cycle after a 2-cycle start-up.
- if_ready = 0, DEPTH = 4 → exactly 4 accepts (pc_adv pulses), then imem_req = 0. if_ready = 1 → 4 pops in order, then req resumes.
- 2 requests outstanding (pc 0x10, 0x11) → flush. Next fetch pc 0x40 → the two late responses are dropped; if_pc = 0x40 is the first valid.
- flush in the same cycle as rvalid and as if_valid & if_ready → no pop and no fill; drop_cnt decrements by exactly 1.
- imem_gnt held 0 → pc_adv = 0 and no allocation; occupancy unchanged.
- Async rst asserted mid-burst → all outputs 0 immediately; restart from pc_in = 0 is clean. With IF_BYPASS_EN, rvalid into an empty queue → if_valid the same cycle.
